// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode constants,
// FSM state encodings, the NOP word and the scoreboard entry layout.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned SB_DEPTH = 3;
    localparam int unsigned FCNT_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rnum;
    } sb_entry_t;

    // A read of src collides with an in-flight write; $0 never collides.
    function automatic logic src_hit(input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input sb_entry_t        e);
        return used && (src != '0) && e.valid && (e.rnum == src);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Three-deep scoreboard of in-flight destination registers (ID/EX, EX/MEM,
// MEM/WB) plus the source-match compare.
// Ports: clk/rst_n; push_valid/push_reg = destination entering ID/EX this
// edge; src_a/src_b with *_used qualifiers = sources read by IF/ID;
// hazard_c = combinational "some source is not yet written back".
module reg_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_reg,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_used,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_used,
    output logic             hazard_c
);

    sb_entry_t sb [SB_DEPTH];

    // Shift every cycle; slot 0 holds whatever entered ID/EX at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SB_DEPTH); k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0] <= '{valid: push_valid, rnum: push_reg};
            for (int k = 1; k < int'(SB_DEPTH); k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // The MEM/WB slot only matters when the register file cannot bypass.
    always_comb begin
        hazard_c = 1'b0;
        for (int k = 0; k < int'(SB_DEPTH); k++) begin
            if ((k < int'(SB_DEPTH) - 1) || (WB_BYPASS == 0)) begin
                hazard_c = hazard_c
                         | src_hit(src_a, src_a_used, sb[k])
                         | src_hit(src_b, src_b_used, sb[k]);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall against in-flight writers, and
// wrong-path flush of IF/ID after a redirect resolved in ID.
// Ports: IF_ID_* = instruction held in IF/ID and its write controls;
// redirect = taken branch/jump this cycle; Enable = PC and IF/ID load;
// bubble = ID/EX loads NOP; flush = IF/ID loads NOP (all three
// combinational); state = FSM state; stall_cnt = saturating stall count.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WB_BYPASS    = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_ID_inst,
    input  logic             IF_ID_RegWrite,
    input  logic             IF_ID_RegDst,
    input  logic             IF_ID_Jal,
    input  logic             redirect,
    output logic             Enable,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs, rt, rd, dest;
    logic              is_nop, rs_used, rt_used, dest_valid;
    logic              hazard_c, issue;
    state_t            state_q, state_nxt;
    logic [FCNT_W-1:0] fcnt_q, fcnt_nxt;

    // Field decode of the instruction waiting in IF/ID.
    assign op      = IF_ID_inst[31:26];
    assign rs      = IF_ID_inst[25:21];
    assign rt      = IF_ID_inst[20:16];
    assign rd      = IF_ID_inst[15:11];
    assign is_nop  = (IF_ID_inst == NOP);
    assign rs_used = !is_nop && (op != OP_J) && (op != OP_JAL);
    assign rt_used = !is_nop && ((op == OP_RTYPE) || (op == OP_BEQ)
                              || (op == OP_BNE)   || (op == OP_SW));

    assign dest       = IF_ID_Jal ? REG_W'(31) : (IF_ID_RegDst ? rd : rt);
    assign dest_valid = IF_ID_RegWrite && (dest != '0);

    reg_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (issue && dest_valid),
        .push_reg   (dest),
        .src_a      (rs),
        .src_a_used (rs_used),
        .src_b      (rt),
        .src_b_used (rt_used),
        .hazard_c   (hazard_c)
    );

    // State and flush-length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            fcnt_q  <= fcnt_nxt;
        end
    end

    // Next state and handshake outputs. STALL re-evaluates exactly like RUN,
    // so the cycle the hazard clears already issues or redirects.
    always_comb begin
        state_nxt = state_q;
        fcnt_nxt  = fcnt_q;
        Enable    = 1'b1;
        bubble    = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                flush    = 1'b1;
                fcnt_nxt = (fcnt_q != '0) ? fcnt_q - FCNT_W'(1) : '0;
                if (fcnt_q <= FCNT_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                if (hazard_c) begin
                    Enable    = 1'b0;
                    bubble    = 1'b1;
                    state_nxt = ST_STALL;
                end else begin
                    issue     = 1'b1;
                    state_nxt = ST_RUN;
                    if (redirect) begin
                        flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
                            state_nxt = ST_FLUSH;
                        end
                    end
                end
            end
        endcase
        // Reset forces the idle handshake regardless of inputs.
        if (!rst_n) begin
            Enable = 1'b1;
            bubble = 1'b0;
            flush  = 1'b0;
            issue  = 1'b0;
        end
    end

    assign state = state_q;

    // Saturating count of cycles with the front end held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!Enable && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
